// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU: the operation-select field
// type and the eight operation-code constants. Every code is defined, so
// there is no illegal-opcode handling anywhere in the ALU.
// Ports: none (package only).
package alu_pkg;

  typedef logic [2:0] alu_ctl_t;

  localparam alu_ctl_t ALU_AND  = 3'b000;
  localparam alu_ctl_t ALU_OR   = 3'b001;
  localparam alu_ctl_t ALU_ADD  = 3'b010;
  localparam alu_ctl_t ALU_XOR  = 3'b011;
  localparam alu_ctl_t ALU_NOR  = 3'b100;
  localparam alu_ctl_t ALU_SLTU = 3'b101;
  localparam alu_ctl_t ALU_SUB  = 3'b110;
  localparam alu_ctl_t ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
// Single shared adder/subtractor used by ADD, SUB, SLT and SLTU.
// Subtraction is done as in1 + ~in2 + 1, so for SUB the carry is the
// "no borrow" flag (1 when in1 >= in2 unsigned).
// Ports:
//   in1, in2  : operands, SIZE+1 bits
//   sub       : 1 selects in1 - in2, 0 selects in1 + in2
//   sum       : result modulo 2^(SIZE+1)
//   carry     : carry out of the MSB
//   overflow  : signed two's-complement overflow of the operation
module alu_addsub #(
  parameter int SIZE = 9
) (
  input  logic [SIZE:0] in1,
  input  logic [SIZE:0] in2,
  input  logic          sub,
  output logic [SIZE:0] sum,
  output logic          carry,
  output logic          overflow
);

  logic [SIZE:0]   b_eff;
  logic [SIZE+1:0] full;

  assign b_eff = sub ? ~in2 : in2;
  // The subtract select doubles as the +1 of the two's-complement negate.
  assign full  = {1'b0, in1} + {1'b0, b_eff} + {{(SIZE+1){1'b0}}, sub};
  assign sum   = full[SIZE:0];
  assign carry = full[SIZE+1];
  // Overflow when both effective operands share a sign the result does not.
  assign overflow = (in1[SIZE] == b_eff[SIZE]) && (sum[SIZE] != in1[SIZE]);

endmodule

// File: rtl/alu.sv
// alu
// Registered arithmetic/logic unit for the MIPS execute stage. Operands and
// operation code are sampled every rising edge; result, carry and zero flag
// appear one cycle later. Fully pipelined, no handshake.
// Optional feature: define ALU_OVERFLOW_EN to add a registered signed
// overflow output for ADD and SUB.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (out=0, carry_out=0, zero=1)
//   ctl       : operation select (codes in alu_pkg)
//   in1, in2  : operands, SIZE+1 bits
//   out       : registered result
//   carry_out : registered carry (ADD carry, SUB no-borrow, else 0)
//   zero      : registered flag, 1 when out is 0
//   overflow  : (ALU_OVERFLOW_EN only) registered signed overflow
module alu
  import alu_pkg::*;
#(
  parameter int SIZE = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    ctl,
  input  logic [SIZE:0] in1,
  input  logic [SIZE:0] in2,
  output logic [SIZE:0] out,
  output logic          carry_out,
  output logic          zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic          overflow
`endif
);

  logic [SIZE:0] as_sum;
  logic          as_carry;
  logic          as_ovf;
  logic          as_sub;

  logic [SIZE:0] next_out;
  logic          next_carry;

  // Only ADD needs the adder in add mode; SUB, SLT and SLTU all compare
  // through the subtraction.
  assign as_sub = (alu_ctl_t'(ctl) != ALU_ADD);

  alu_addsub #(.SIZE(SIZE)) u_addsub (
    .in1      (in1),
    .in2      (in2),
    .sub      (as_sub),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  // Operation mux. SLTU is "borrow occurred"; SLT is the true sign of the
  // difference, i.e. raw sign corrected by overflow.
  always_comb begin
    next_out   = '0;
    next_carry = 1'b0;
    case (alu_ctl_t'(ctl))
      ALU_AND:  next_out = in1 & in2;
      ALU_OR:   next_out = in1 | in2;
      ALU_ADD: begin
        next_out   = as_sum;
        next_carry = as_carry;
      end
      ALU_XOR:  next_out = in1 ^ in2;
      ALU_NOR:  next_out = ~(in1 | in2);
      ALU_SLTU: next_out = {{SIZE{1'b0}}, ~as_carry};
      ALU_SUB: begin
        next_out   = as_sum;
        next_carry = as_carry;
      end
      ALU_SLT:  next_out = {{SIZE{1'b0}}, as_sum[SIZE] ^ as_ovf};
      default:  next_out = '0;
    endcase
  end

  // Output registers. Reset wins over any operation presented on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out       <= next_out;
      carry_out <= next_carry;
      zero      <= (next_out == '0);
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic next_ovf;

  assign next_ovf = ((alu_ctl_t'(ctl) == ALU_ADD) || (alu_ctl_t'(ctl) == ALU_SUB)) && as_ovf;

  // Overflow flag shares the reset and load timing of the main outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= next_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu
// Self-checking bench for alu (SIZE = 9). Directed vectors followed by
// randomized vectors, one operation per cycle, checked against an
// arithmetic reference model one cycle after each stimulus edge.
module tb_alu;

  localparam int SIZE = 9;
  localparam int W    = SIZE + 1;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << SIZE;

  logic          clk;
  logic          rst_n;
  logic [2:0]    ctl;
  logic [SIZE:0] in1;
  logic [SIZE:0] in2;
  logic [SIZE:0] out;
  logic          carry_out;
  logic          zero;
`ifdef ALU_OVERFLOW_EN
  logic          overflow;
`endif

  alu #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl       (ctl),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .carry_out (carry_out),
    .zero      (zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [SIZE:0] exp_out;
  logic          exp_carry;
  logic          exp_zero;
  logic          exp_ovf;
  string         cur_tag;

  typedef struct {
    bit   rst_n;
    int   ctl;
    int   a;
    int   b;
    string tag;
  } step_t;

  step_t steps[$];

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic computeExpected(input int c, input int a, input int b, input bit r);
    int sa, sb, res, sres;
    exp_carry = 1'b0;
    exp_ovf   = 1'b0;
    res       = 0;
    if (!r) begin
      res = 0;
    end else begin
      sa = (a >= HALF) ? a - MOD : a;
      sb = (b >= HALF) ? b - MOD : b;
      case (c)
        0: res = a & b;
        1: res = a | b;
        2: begin
          res       = (a + b) % MOD;
          exp_carry = ((a + b) >= MOD);
          sres      = sa + sb;
          exp_ovf   = (sres > HALF - 1) || (sres < -HALF);
        end
        3: res = a ^ b;
        4: res = (MOD - 1) - (a | b);
        5: res = (a < b) ? 1 : 0;
        6: begin
          res       = (a - b + MOD) % MOD;
          exp_carry = (a >= b);
          sres      = sa - sb;
          exp_ovf   = (sres > HALF - 1) || (sres < -HALF);
        end
        default: res = (sa < sb) ? 1 : 0;
      endcase
    end
    exp_out  = res[SIZE:0];
    exp_zero = (res == 0);
  endtask

  // Drive one operation in the low phase so it is stable at the next edge.
  task automatic applyStimulus(input step_t s);
    @(negedge clk);
    rst_n = s.rst_n;
    ctl   = s.ctl[2:0];
    in1   = s.a[SIZE:0];
    in2   = s.b[SIZE:0];
    cur_tag = s.tag;
    computeExpected(s.ctl, s.a, s.b, s.rst_n);
  endtask

  // Sample just after the edge that consumed the stimulus.
  task automatic checkOutput();
    @(posedge clk);
    #1;
    vectors++;
    assert (out === exp_out) else begin
      miscompares++;
      $error("[TB] FAIL %s out: got %0d expected %0d", cur_tag, out, exp_out);
    end
    assert (carry_out === exp_carry) else begin
      miscompares++;
      $error("[TB] FAIL %s carry_out: got %0b expected %0b", cur_tag, carry_out, exp_carry);
    end
    assert (zero === exp_zero) else begin
      miscompares++;
      $error("[TB] FAIL %s zero: got %0b expected %0b", cur_tag, zero, exp_zero);
    end
`ifdef ALU_OVERFLOW_EN
    assert (overflow === exp_ovf) else begin
      miscompares++;
      $error("[TB] FAIL %s overflow: got %0b expected %0b", cur_tag, overflow, exp_ovf);
    end
`endif
  endtask

  task automatic push(input bit r, input int c, input int a, input int b, input string t);
    step_t s;
    s.rst_n = r;
    s.ctl   = c;
    s.a     = a;
    s.b     = b;
    s.tag   = t;
    steps.push_back(s);
  endtask

  initial begin
    rst_n = 1'b0;
    ctl   = '0;
    in1   = '0;
    in2   = '0;

    // Reset held two edges with non-zero inputs, then release.
    push(0, 2, 768, 512, "reset0");
    push(0, 6, 100, 7,   "reset1");
    push(1, 1, 768, 128, "after_reset_or");
    // Logic operations.
    push(1, 0, 512, 256, "and");
    push(1, 1, 768, 128, "or");
    push(1, 3, 768, 128, "xor");
    push(1, 4, 512, 256, "nor");
    // ADD.
    push(1, 2, 512, 256, "add_nc");
    push(1, 2, 768, 512, "add_carry");
    push(1, 2, 256, 256, "add_ovf");
    // SUB.
    push(1, 6, 512, 256, "sub_pos");
    push(1, 6, 256, 512, "sub_borrow");
    push(1, 6, 512, 512, "sub_zero");
    // Set-less-than.
    push(1, 7, 512, 513, "slt_513");
    push(1, 7, 512, 512, "slt_512");
    push(1, 7, 512, 511, "slt_511");
    push(1, 5, 512, 513, "sltu_513");
    push(1, 5, 512, 511, "sltu_511");
    // Mid-stream reset discards only the op on that edge.
    push(1, 2, 3, 4,     "pre_midreset");
    push(0, 2, 5, 6,     "midreset");
    push(1, 6, 9, 2,     "post_midreset");
    // Back-to-back through all eight codes.
    for (int c = 0; c < 8; c++) begin
      push(1, c, 300 + 37 * c, 611 - 53 * c, $sformatf("b2b_%0d", c));
    end
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      push(($urandom_range(0, 15) != 0), $urandom_range(0, 7),
           $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
           $sformatf("rand_%0d", i));
    end

    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
